// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with pointer-derived full/empty, registered threshold flags and overflow/underflow pulses.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a 1-cycle read latency.
module param_sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_accept;
    logic              wr_accept;

    // A read at full frees a slot in the same edge, so the write may proceed.
    always_comb begin
        rd_accept = rd_en && !empty_q;
        wr_accept = wr_en && (!full_q || rd_accept);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + PW'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - PW'(1);
        end
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        afull_d  = (count_d >= AF_CNT);
        aempty_d = (count_d <= AE_CNT);
        ovf_d    = wr_en && !wr_accept;
        unf_d    = rd_en && !rd_accept;
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Head after this edge; bypass wdata when the new head is being written now.
    always_comb begin
        rdata_d = rdata_q;
        if (!empty_d) begin
            if (wr_accept && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem[rd_ptr_d[AW-1:0]];
            end
        end
    end
`else
    always_comb begin
        rdata_d = rdata_q;
        if (rd_accept) begin
            rdata_d = mem[rd_ptr_q[AW-1:0]];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata        = rdata_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo (DATA_W=8, DEPTH=16): queue model compared every cycle plus directed literal checks.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic [7:0] rdata;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    param_sync_fifo #(.DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain queue of stored words, oldest at the front.
    logic [7:0] mq[$];
    logic [7:0] m_rdata;
    bit         m_ovf, m_unf;
    bit         m_rd_ok, m_wr_ok;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_rdata = 8'h00;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            m_rd_ok = rd_en && (mq.size() > 0);
            m_wr_ok = wr_en && ((mq.size() < 16) || m_rd_ok);
            m_unf   = rd_en && !m_rd_ok;
            m_ovf   = wr_en && !m_wr_ok;
            if (m_rd_ok) m_rdata = mq.pop_front();
            if (m_wr_ok) mq.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        if (started && rst) begin
            chk("cmp_count", 64'(count), 64'(mq.size()));
            chk("cmp_full", 64'(full), 64'(mq.size() == 16));
            chk("cmp_empty", 64'(empty), 64'(mq.size() == 0));
            chk("cmp_almost_full", 64'(almost_full), 64'(mq.size() >= 14));
            chk("cmp_almost_empty", 64'(almost_empty), 64'(mq.size() <= 2));
            chk("cmp_overflow", 64'(overflow), 64'(m_ovf));
            chk("cmp_underflow", 64'(underflow), 64'(m_unf));
            chk("cmp_rdata", 64'(rdata), 64'(m_rdata));
        end
    end

    // Called at a falling edge; applies inputs across one rising edge, returns at the next falling edge.
    task automatic step(input bit w, input logic [7:0] d, input bit r);
        wr_en = w;
        wdata = d;
        rd_en = r;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_almost_empty"}, 64'(almost_empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_almost_full"}, 64'(almost_full), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_underflow"}, 64'(underflow), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
    endtask

    initial begin
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        started = 1'b1;

        // Fill with 0x01..0x10, watching almost_full cross at 14.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 13) chk("af_at_13", 64'(almost_full), 64'd0);
            if (i == 14) chk("af_at_14", 64'(almost_full), 64'd1);
        end
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_full", 64'(full), 64'd1);
        step(1'b1, 8'h11, 1'b0);
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd16);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 64'(overflow), 64'd0);

        // Drain, checking order and almost_empty crossing at 2.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_rdata", 64'(rdata), 64'(i));
            if (i == 13) chk("ae_at_3", 64'(almost_empty), 64'd0);
            if (i == 14) chk("ae_at_2", 64'(almost_empty), 64'd1);
        end
        chk("drain_empty", 64'(empty), 64'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("unf_pulse", 64'(underflow), 64'd1);
        chk("unf_rdata_hold", 64'(rdata), 64'h10);

        // Simultaneous read/write at full.
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        chk("rw_full_rdata", 64'(rdata), 64'h01);
        chk("rw_full_count", 64'(count), 64'd16);
        chk("rw_full_ovf", 64'(overflow), 64'd0);
        for (int i = 2; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("rw_drain_rdata", 64'(rdata), 64'(i));
        end
        step(1'b0, 8'h00, 1'b1);
        chk("rw_last_aa", 64'(rdata), 64'hAA);
        chk("rw_empty", 64'(empty), 64'd1);

        // 40 writes interleaved with 40 reads; pointers wrap past 2*DEPTH.
        step(1'b1, 8'h30, 1'b0);
        for (int i = 1; i < 40; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b1);
            chk("wrap_rdata", 64'(rdata), 64'(8'h30 + i - 1));
        end
        step(1'b0, 8'h00, 1'b1);
        chk("wrap_last", 64'(rdata), 64'h57);
        chk("wrap_empty", 64'(empty), 64'd1);

        // Asynchronous reset mid-burst with 7 entries held.
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        chk("pre_rst_count", 64'(count), 64'd7);
        wr_en = 1'b1;
        wdata = 8'hEE;
        #2 rst = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b1;
        chk("post_rst_empty", 64'(empty), 64'd1);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_rdata", 64'(rdata), 64'h5A);
        chk("post_rst_empty2", 64'(empty), 64'd1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
